// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the MIPS-subset datapath: sequences fetch, decode and the
// per-class execute phases, and drives every datapath control strobe.
module mc_ctrl_fsm #(
   parameter int unsigned STATE_W  = 4,
   parameter bit          LOGIC_ZX = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               branch_ne,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_src,
   output logic               ext_op,
   output logic               illegal_op,
   output logic [STATE_W-1:0] dbg_state
);

   localparam logic [STATE_W-1:0] StIdle   = STATE_W'(0);
   localparam logic [STATE_W-1:0] StFetch  = STATE_W'(1);
   localparam logic [STATE_W-1:0] StDecode = STATE_W'(2);
   localparam logic [STATE_W-1:0] StMemAdr = STATE_W'(3);
   localparam logic [STATE_W-1:0] StMemRd  = STATE_W'(4);
   localparam logic [STATE_W-1:0] StMemWb  = STATE_W'(5);
   localparam logic [STATE_W-1:0] StMemWr  = STATE_W'(6);
   localparam logic [STATE_W-1:0] StExec   = STATE_W'(7);
   localparam logic [STATE_W-1:0] StAluWb  = STATE_W'(8);
   localparam logic [STATE_W-1:0] StBranch = STATE_W'(9);
   localparam logic [STATE_W-1:0] StIexec  = STATE_W'(10);
   localparam logic [STATE_W-1:0] StIwb    = STATE_W'(11);
   localparam logic [STATE_W-1:0] StJump   = STATE_W'(12);

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpBne   = 6'h05;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpAndi  = 6'h0C;
   localparam logic [5:0] OpOri   = 6'h0D;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;

   localparam logic [5:0] FnAdd = 6'h20;
   localparam logic [5:0] FnSub = 6'h22;
   localparam logic [5:0] FnAnd = 6'h24;
   localparam logic [5:0] FnOr  = 6'h25;
   localparam logic [5:0] FnSlt = 6'h2A;

   logic [STATE_W-1:0] state_q, state_d;

   logic is_rtype, is_load, is_store, is_branch, is_addi, is_logic_imm, is_jump;
   logic funct_ok, op_legal, imm_ext;
   logic [STATE_W-1:0] dispatch;

   // Branch polarity is applied by the datapath; the zero flag never enters this FSM.
   logic unused_zero;
   assign unused_zero = zero;

   // Instruction class decode from the live IR fields.
   always_comb begin
      funct_ok     = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                     (funct == FnOr)  || (funct == FnSlt);
      is_rtype     = (op == OpRtype) && funct_ok;
      is_load      = (op == OpLw);
      is_store     = (op == OpSw);
      is_branch    = (op == OpBeq) || (op == OpBne);
      is_addi      = (op == OpAddi);
      is_logic_imm = (op == OpAndi) || (op == OpOri);
      is_jump      = (op == OpJ);
      op_legal     = is_rtype || is_load || is_store || is_branch || is_addi ||
                     is_logic_imm || is_jump;
      imm_ext      = is_addi ? 1'b1 : !LOGIC_ZX;
   end

   always_comb begin
      dispatch = StFetch;
      if (is_rtype) begin
         dispatch = StExec;
      end else if (is_load || is_store) begin
         dispatch = StMemAdr;
      end else if (is_branch) begin
         dispatch = StBranch;
      end else if (is_addi || is_logic_imm) begin
         dispatch = StIexec;
      end else if (is_jump) begin
         dispatch = StJump;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   state_d = StFetch;
         StFetch:  if (mem_ready) state_d = StDecode;
         StDecode: state_d = dispatch;
         StMemAdr: state_d = is_store ? StMemWr : StMemRd;
         StMemRd:  if (mem_ready) state_d = StMemWb;
         StMemWb:  state_d = StFetch;
         StMemWr:  if (mem_ready) state_d = StFetch;
         StExec:   state_d = StAluWb;
         StAluWb:  state_d = StFetch;
         StBranch: state_d = StFetch;
         StIexec:  state_d = StIwb;
         StIwb:    state_d = StFetch;
         StJump:   state_d = StFetch;
         default:  state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_src        = 2'b00;
      ext_op        = 1'b1;
      illegal_op    = 1'b0;
      case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            // IR and PC+4 commit only in the cycle the memory completes.
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         StDecode: begin
            alu_src_b  = 2'b11;
            illegal_op = !op_legal;
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         StMemRd: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         StMemWr: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         StExec: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         StAluWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         StBranch: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_src        = 2'b01;
            pc_write_cond = 1'b1;
            branch_ne     = op[0];
         end
         StIexec: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = is_addi ? 2'b00 : 2'b11;
            ext_op    = imm_ext;
         end
         StIwb: begin
            reg_write = 1'b1;
            ext_op    = imm_ext;
         end
         StJump: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: an instruction-level model expands each instruction into
// its expected per-cycle control vectors; a negedge monitor pops and compares them.
module tb_mc_ctrl_fsm;

   localparam bit LOGIC_ZX = 1'b1;

   typedef struct packed {
      logic pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
      logic mem_to_reg, reg_dst, reg_write, alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic ext_op, illegal_op;
      logic [3:0] dbg_state;
   } ctl_t;

   typedef struct {
      int         ready;
      logic [5:0] op;
      logic [5:0] funct;
      ctl_t       exp;
      string      tag;
   } cyc_t;

   typedef struct {
      ctl_t  exp;
      string tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [5:0] op = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] dbg_state;

   mc_ctrl_fsm #(.STATE_W(4), .LOGIC_ZX(LOGIC_ZX)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .ext_op(ext_op), .illegal_op(illegal_op), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   cyc_t       stim_q[$];
   exp_t       exp_q[$];
   int         n_pass = 0;
   int         n_total = 0;
   logic       mon_en = 1'b0;
   logic [5:0] last_op = '0;
   logic [5:0] last_funct = '0;

   function automatic ctl_t at_state(int st);
      ctl_t c;
      c = '0;
      c.ext_op = 1'b1;
      c.dbg_state = 4'(st);
      return c;
   endfunction

   function automatic bit is_legal(logic [5:0] o, logic [5:0] f);
      if (o == 6'h00) return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      return o inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h02};
   endfunction

   // ready < 0 means the cycle does not consume mem_ready, so drive a random value.
   task automatic add(int ready, logic [5:0] o, logic [5:0] f, ctl_t c, string tag);
      cyc_t r;
      r.ready = ready;
      r.op = o;
      r.funct = f;
      r.exp = c;
      r.tag = tag;
      stim_q.push_back(r);
   endtask

   // Expands one instruction into its expected cycle sequence, waits included.
   task automatic gen_instr(logic [5:0] o, logic [5:0] f, int fw, int mw);
      ctl_t c;
      for (int i = 0; i < fw; i++) begin
         c = at_state(1);
         c.mem_read = 1'b1;
         c.alu_src_b = 2'b01;
         add(0, last_op, last_funct, c, "fetch_wait");
      end
      c = at_state(1);
      c.mem_read = 1'b1;
      c.alu_src_b = 2'b01;
      c.ir_write = 1'b1;
      c.pc_write = 1'b1;
      add(1, last_op, last_funct, c, "fetch");
      c = at_state(2);
      c.alu_src_b = 2'b11;
      c.illegal_op = !is_legal(o, f);
      add(-1, o, f, c, "decode");
      if (is_legal(o, f)) begin
         if (o == 6'h00) begin
            c = at_state(7); c.alu_src_a = 1'b1; c.alu_op = 2'b10;
            add(-1, o, f, c, "exec");
            c = at_state(8); c.reg_write = 1'b1; c.reg_dst = 1'b1;
            add(-1, o, f, c, "alu_wb");
         end else if (o == 6'h23 || o == 6'h2B) begin
            c = at_state(3); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            add(-1, o, f, c, "mem_adr");
            for (int i = 0; i <= mw; i++) begin
               if (o == 6'h23) begin
                  c = at_state(4); c.mem_read = 1'b1;
               end else begin
                  c = at_state(6); c.mem_write = 1'b1;
               end
               c.i_or_d = 1'b1;
               add((i == mw) ? 1 : 0, o, f, c, (o == 6'h23) ? "mem_rd" : "mem_wr");
            end
            if (o == 6'h23) begin
               c = at_state(5); c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
               add(-1, o, f, c, "mem_wb");
            end
         end else if (o == 6'h04 || o == 6'h05) begin
            c = at_state(9); c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01;
            c.pc_write_cond = 1'b1; c.branch_ne = (o == 6'h05);
            add(-1, o, f, c, "branch");
         end else if (o == 6'h02) begin
            c = at_state(12); c.pc_src = 2'b10; c.pc_write = 1'b1;
            add(-1, o, f, c, "jump");
         end else begin
            c = at_state(10); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            c.alu_op = (o == 6'h08) ? 2'b00 : 2'b11;
            c.ext_op = (o == 6'h08) ? 1'b1 : !LOGIC_ZX;
            add(-1, o, f, c, "i_exec");
            c.dbg_state = 4'd11; c.alu_src_a = 1'b0; c.alu_src_b = 2'b00; c.alu_op = 2'b00;
            c.reg_write = 1'b1;
            add(-1, o, f, c, "i_wb");
         end
      end
      last_op = o;
      last_funct = f;
   endtask

   task automatic run_stim();
      cyc_t r;
      while (stim_q.size() > 0) begin
         r = stim_q.pop_front();
         @(posedge clk);
         #1;
         mem_ready = (r.ready < 0) ? 1'($urandom_range(0, 1)) : 1'(r.ready);
         op = r.op;
         funct = r.funct;
         zero = 1'($urandom_range(0, 1));
         exp_q.push_back('{r.exp, r.tag});
      end
   endtask

   task automatic idle_cycle(string tag, logic rst_val);
      @(posedge clk);
      #1;
      rst_n = rst_val;
      mem_ready = 1'($urandom_range(0, 1));
      exp_q.push_back('{at_state(0), tag});
   endtask

   ctl_t act;
   exp_t cur;
   always @(negedge clk) begin
      if (mon_en) begin
         act = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                ext_op, illegal_op, dbg_state};
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_underflow: dut=%h expected=<none>", act);
         end else begin
            cur = exp_q.pop_front();
            if (act === cur.exp) n_pass++;
            else $display("FAIL %s: dut=%h expected=%h (t=%0t)", cur.tag, act, cur.exp, $time);
         end
      end
   end

   logic [5:0] ops[10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h02, 6'h00};
   logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

   initial begin
      logic [5:0] o, f;
      #2 rst_n = 1'b0;
      mon_en = 1'b1;
      idle_cycle("reset_hold", 1'b0);
      idle_cycle("reset_hold", 1'b0);
      idle_cycle("reset_release", 1'b1);

      gen_instr(6'h23, 6'h00, 0, 3);     // lw, three memory wait cycles
      gen_instr(6'h0C, 6'h00, 1, 0);     // andi zero-extends
      gen_instr(6'h08, 6'h00, 0, 0);     // addi sign-extends
      gen_instr(6'h0D, 6'h00, 0, 0);
      gen_instr(6'h04, 6'h00, 0, 0);
      gen_instr(6'h05, 6'h00, 2, 0);
      gen_instr(6'h02, 6'h00, 0, 0);
      gen_instr(6'h00, 6'h20, 0, 0);
      gen_instr(6'h2B, 6'h00, 0, 1);
      gen_instr(6'h3F, 6'h00, 0, 0);     // illegal opcode
      gen_instr(6'h00, 6'h3F, 0, 0);     // illegal funct
      run_stim();

      // Reset asserted mid-cycle while a store waits on memory.
      gen_instr(6'h2B, 6'h00, 0, 5);
      repeat (4) void'(stim_q.pop_back());
      run_stim();
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      exp_q.push_back('{at_state(0), "reset_mid_memwr"});
      #2 rst_n = 1'b0;
      idle_cycle("reset_hold", 1'b0);
      idle_cycle("reset_release", 1'b1);
      gen_instr(6'h00, 6'h2A, 0, 0);
      run_stim();

      for (int n = 0; n < 200; n++) begin
         o = ops[$urandom_range(0, 9)];
         f = fns[$urandom_range(0, 4)];
         if ($urandom_range(0, 9) == 0) o = 6'($urandom);
         if (o == 6'h00 && $urandom_range(0, 7) == 0) f = 6'($urandom);
         gen_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 2));
         run_stim();
      end

      @(posedge clk);
      #1;
      mon_en = 1'b0;
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
